// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and widths for the shared adder arbiter
package arb_pkg;

    localparam int DATA_W = 64;
    localparam int ID_W   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/cla64bit.sv
// rtl/cla64bit.sv - 64-bit adder, 4-bit lookahead groups with rippled group carry
module Cla64bit (
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic [63:0] Sum,
    output logic        overflow
);

    logic [63:0] g;
    logic [63:0] p;
    logic [3:0]  gg;
    logic [3:0]  pp;
    logic [4:0]  c;
    logic        carry;

    assign g = A & B;
    assign p = A ^ B;

    // After the loop, c holds the top group: c[3] is carry into bit 63, c[4] carry out.
    always_comb begin
        carry    = 1'b0;
        gg       = '0;
        pp       = '0;
        c        = '0;
        Sum      = '0;
        for (int k = 0; k < 16; k++) begin
            gg   = g[4*k +: 4];
            pp   = p[4*k +: 4];
            c[0] = carry;
            c[1] = gg[0] | (pp[0] & c[0]);
            c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
            c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & c[0]);
            c[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c[0]);
            Sum[4*k +: 4] = pp ^ c[3:0];
            carry = c[4];
        end
        overflow = c[3] ^ c[4];
    end

endmodule

// File: rtl/shared_adder_arbiter.sv
// rtl/shared_adder_arbiter.sv - round-robin arbiter sharing one 64-bit adder between two requesters
module shared_adder_arbiter
    import arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_overflow
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

    logic              any_valid;
    logic [ID_W-1:0]   grant;
    logic [DATA_W-1:0] add_sum;
    logic              add_ovf;

    Cla64bit u_cla (
        .A        (a_q),
        .B        (b_q),
        .Sum      (add_sum),
        .overflow (add_ovf)
    );

    // On a tie the requester that did not win last time is served.
    assign any_valid = req0_valid | req1_valid;
    assign grant     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_id_d     = rsp_id_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && any_valid) begin
                    req0_ready   = (grant == '0);
                    req1_ready   = (grant != '0);
                    a_d          = (grant != '0) ? req1_a : req0_a;
                    b_d          = (grant != '0) ? req1_b : req0_b;
                    id_d         = grant;
                    last_grant_d = grant;
                    state_d      = CALC;
                end
            end
            CALC: begin
                rsp_sum_d   = add_sum;
                rsp_ovf_d   = add_ovf;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= '1;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_sum      = rsp_sum_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_id       = rsp_id_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb/tb_shared_adder_arbiter.sv - randomized bench with transaction-level reference model
module tb_shared_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_overflow;
    logic [63:0] rsp_sum;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: one outstanding transaction, visible one edge after acceptance
    bit          m_busy, m_shown, m_last, m_zero, m_id;
    logic [63:0] m_a, m_b, e_sum;
    bit          e_ovf, e_id;

    always #5 clk = ~clk;

    shared_adder_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_ready   (req1_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_overflow (rsp_overflow)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            3:       v = 64'h8000_0000_0000_0000;
            4:       v = 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic step(input bit v0, input bit v1,
                        input logic [63:0] a0, input logic [63:0] b0,
                        input logic [63:0] a1, input logic [63:0] b1,
                        input bit rdy, input bit rstn);
        bit          e_r0, e_r1, win;
        logic [64:0] full;
        @(negedge clk);
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        rsp_ready = rdy; rst_n = rstn;
        #1;
        e_r0 = 1'b0; e_r1 = 1'b0;
        if (rstn && !m_busy) begin
            if (v0 && v1) begin
                e_r0 = (m_last == 1'b1);
                e_r1 = (m_last == 1'b0);
            end else begin
                e_r0 = v0;
                e_r1 = v1;
            end
        end
        check_val("req0_ready", {63'd0, req0_ready}, {63'd0, e_r0});
        check_val("req1_ready", {63'd0, req1_ready}, {63'd0, e_r1});
        check_val("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_busy && m_shown});
        if (m_busy && m_shown) begin
            check_val("rsp_sum", rsp_sum, e_sum);
            check_val("rsp_id", {63'd0, rsp_id}, {63'd0, e_id});
            check_val("rsp_overflow", {63'd0, rsp_overflow}, {63'd0, e_ovf});
        end else if (m_zero) begin
            check_val("rsp_sum_reset", rsp_sum, 64'd0);
            check_val("rsp_id_reset", {63'd0, rsp_id}, 64'd0);
            check_val("rsp_overflow_reset", {63'd0, rsp_overflow}, 64'd0);
        end
        @(posedge clk);
        if (!rstn) begin
            m_busy = 1'b0; m_shown = 1'b0; m_last = 1'b1; m_zero = 1'b1;
        end else if (!m_busy) begin
            if (v0 || v1) begin
                win     = (v0 && v1) ? !m_last : v1;
                m_id    = win;
                m_a     = win ? a1 : a0;
                m_b     = win ? b1 : b0;
                m_last  = win;
                m_busy  = 1'b1;
                m_shown = 1'b0;
            end
        end else if (!m_shown) begin
            full    = {1'b0, m_a} + {1'b0, m_b};
            e_sum   = full[63:0];
            e_ovf   = (m_a[63] == m_b[63]) && (full[63] != m_a[63]);
            e_id    = m_id;
            m_shown = 1'b1;
            m_zero  = 1'b0;
        end else if (rdy) begin
            m_busy  = 1'b0;
            m_shown = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        m_busy = 1'b0; m_shown = 1'b0; m_last = 1'b1; m_zero = 1'b1;
        m_id = 1'b0; m_a = '0; m_b = '0; e_sum = '0; e_ovf = 1'b0; e_id = 1'b0;

        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 64'd5, 64'd7, 0, 0, 1, 1);
        repeat (3) step(0, 0, 64'd99, 64'd99, 0, 0, 1, 1);
        step(0, 1, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 1);
        repeat (3) step(0, 0, 0, 0, 64'd3, 64'd4, 1, 1);
        step(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 1, 1);
        repeat (3) step(0, 0, 64'd0, 64'd0, 0, 0, 1, 1);

        step(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++)
            step(1, 1, 64'd10 + i, 64'd1, 64'd100 + i, 64'd2, 1, 1);

        step(1, 1, 64'd20, 64'd22, 64'd30, 64'd33, 0, 1);
        for (int i = 0; i < 7; i++)
            step(1, 1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), 0, 1);
        repeat (3) step(1, 1, 64'd1, 64'd2, 64'd3, 64'd4, 1, 1);

        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 64'd1000, 64'd1, 0, 0, 1, 1);
        step(1, 1, 64'd5, 64'd5, 64'd6, 64'd6, 1, 0);
        repeat (5) step(1, 1, 64'd7, 64'd8, 64'd9, 64'd10, 1, 1);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 rnd_op(), rnd_op(), rnd_op(), rnd_op(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 63) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
